p_out_serializer: RTL and testbench
===================================

Name: p_out_serializer

Overview:
- Drain/readout end of the DSP48A1 datapath: captures a P_WIDTH-bit result (P register output) and streams it out as W_WIDTH-bit words over a valid/ready handshake.
- Sits between the P stage and an 18-bit consumer bus (cascade port, host readout FIFO).
- Counterpart to the per-port input capture registers: those load narrow operands in; this block unloads the wide result out.

Parameters:
- P_WIDTH, 48, width of captured result.
- W_WIDTH, 18, width of each output word.
- MSW_FIRST, 0, 0 = least-significant word first; 1 = most-significant word first.
- NWORDS (localparam) = ceil(P_WIDTH / W_WIDTH); 3 at defaults.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- p_in  in  P_WIDTH  result word to capture.
- p_load  in  1  capture request; accepted when p_load & load_ready.
- load_ready  out  1  block can accept a new capture this cycle.
- dout  out  W_WIDTH  current output word (registered).
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts dout this cycle.
- dout_last  out  1  dout is the final word of the current result.
- busy  out  1  a result is being streamed (state SEND).

Behaviour:
- Reset (async, rst high):
  - state = IDLE; shift register, dout, word counter cleared to 0.
  - dout_valid = 0, dout_last = 0, busy = 0.
  - p_load is ignored while rst is high.
- States:
  - IDLE: load_ready = 1.
  - SEND: load_ready = dout_last & dout_ready, which allows back-to-back results.
- Capture:
  - On an accepted load, p_in is zero-padded to NWORDS*W_WIDTH bits and latched.
  - Counter is set to NWORDS-1 and the state goes to SEND.
  - The first word appears on dout with dout_valid = 1 the cycle after the load edge (latency 1).
- Transfer: a word transfers on a posedge where dout_valid & dout_ready.
  - On a non-final transfer: shift by W_WIDTH (right if MSW_FIRST=0, left if 1), decrement the counter, and present the next word the following cycle.
- Final word: dout_last = 1 exactly when the counter is 0 and dout_valid = 1. On the final transfer:
  - If p_load is also high, capture the new p_in and stay in SEND with no bubble.
  - Otherwise go to IDLE: dout_valid = 0, dout_last = 0, busy = 0. dout keeps its last value (don't-care).
- Backpressure: while dout_valid & !dout_ready, dout, dout_last and the counter hold stable for any number of cycles.
- p_load in SEND before the final transfer is not accepted (load_ready = 0). p_in is sampled only on an accepted load.
- Reset asserted mid-stream: the stream is abandoned immediately and outputs take reset values; after release the block is in IDLE with no residual words.
- P_WIDTH an exact multiple of W_WIDTH: no padding; the final word is full width.

Optional Feature:
- Macro: P_OUT_SERIALIZER_SIGN_EXT_EN.
- Defined: the padding bits of the partial word are filled with p_in[P_WIDTH-1] (sign extension), so the consumer can treat each result as signed.
- Undefined: padding bits are 0.
- Both builds keep identical timing and handshake behaviour.

Decomposition:
- Shared package dsp_pkg holds:
  - state enum (IDLE, SEND);
  - a ceil-divide function used to compute NWORDS;
  - default width constants (P_W = 48, OPW = 18).
- No sub-module; the block is a single FSM plus shift register plus counter.

Test Plan:
- Single result, ready held at 1, p_in = 48'h0000_0004_0001, MSW_FIRST = 0 -> dout = 18'h00001, 18'h00001, 18'h00000 on 3 consecutive cycles; dout_last only on the third; busy falls the next cycle.
- Padding check, p_in = 48'hFFFF_FFFF_FFFF -> words 18'h3FFFF, 18'h3FFFF, then 18'h00FFF (18'h3FFFF with P_OUT_SERIALIZER_SIGN_EXT_EN).
- Backpressure: dout_ready low for 4 cycles after word 0 -> dout and dout_valid stable for all 4 cycles; no word lost or duplicated; total 3 transfers.
- Back-to-back: p_load high with the final transfer of result A (48'h1) and p_in = B (48'h2) -> B's word 0 = 18'h00002 in the very next cycle with no dout_valid gap.
- MSW_FIRST = 1, p_in = 48'h0000_0004_0001 -> order 18'h00000, 18'h00001, 18'h00001.
- Async rst pulse (mid-cycle) during word 1 -> dout_valid, busy and dout_last go 0 immediately; load_ready = 1 after release; a new load streams correctly.

Source files
------------

// File: rtl/dsp_pkg.sv
// ============================================================================
//  Module      : dsp_pkg
//  Description : Shared types, constants and helpers for the DSP48A1-style
//                datapath blocks (serializer FSM states, default widths,
//                ceil-divide used to size word counts).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dsp_pkg;

    // Default datapath widths: P register result and consumer bus word.
    localparam int P_W = 48;
    localparam int OPW = 18;

    // Serializer control states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Integer ceiling division, used to size the number of output words.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage : dsp_pkg

`default_nettype wire

// File: rtl/p_out_serializer.sv
// ============================================================================
//  Module      : p_out_serializer
//  Description : Readout end of the DSP datapath. Captures a P_WIDTH-bit
//                result and streams it as NWORDS words of W_WIDTH bits over
//                a valid/ready handshake, LSW or MSW first. A new result may
//                be loaded on the final transfer of the previous one, giving
//                gap-free back-to-back streaming.
//  Options     : define P_OUT_SERIALIZER_SIGN_EXT_EN to fill the padding bits
//                of the partial word with the result's sign bit instead of 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module p_out_serializer
    import dsp_pkg::*;
#(
    parameter int P_WIDTH   = P_W,
    parameter int W_WIDTH   = OPW,
    parameter int MSW_FIRST = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_WIDTH-1:0] p_in,
    input  logic               p_load,
    output logic               load_ready,
    output logic [W_WIDTH-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy
);

    localparam int NWORDS = ceil_div(P_WIDTH, W_WIDTH);
    localparam int SR_W   = NWORDS * W_WIDTH;
    localparam int PAD_W  = SR_W - P_WIDTH;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [CNT_W-1:0] C_FIRST_CNT = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SR_W-1:0]   r_shift;
    logic [SR_W-1:0]   w_padded;
    logic [SR_W-1:0]   w_shifted;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_xfer;
    logic              w_load_acc;
    logic              w_cnt_zero;

    // The counter holds the number of words still to go after the current one,
    // so the word on dout is final exactly when it reaches zero.
    assign w_cnt_zero = (r_cnt == '0);
    assign busy       = (r_state == SEND);
    assign dout_valid = busy;
    assign dout_last  = busy & w_cnt_zero;
    assign w_xfer     = dout_valid & dout_ready;

    // A load is taken when idle, or when the last word leaves this cycle.
    assign load_ready = (r_state == IDLE) | (dout_last & dout_ready);
    assign w_load_acc = p_load & load_ready;

    // Widen the captured result to a whole number of words.
    if (PAD_W == 0) begin : g_no_pad
        assign w_padded = p_in;
    end else begin : g_pad
        logic w_pad_bit;
`ifdef P_OUT_SERIALIZER_SIGN_EXT_EN
        assign w_pad_bit = p_in[P_WIDTH-1];
`else
        assign w_pad_bit = 1'b0;
`endif
        assign w_padded = {{PAD_W{w_pad_bit}}, p_in};
    end

    // Word order: dout is taken from the end of the shift register that
    // drains first, and the register moves toward that end on each transfer.
    if (MSW_FIRST != 0) begin : g_msw_first
        assign dout      = r_shift[SR_W-1 -: W_WIDTH];
        assign w_shifted = r_shift << W_WIDTH;
    end else begin : g_lsw_first
        assign dout      = r_shift[W_WIDTH-1:0];
        assign w_shifted = r_shift >> W_WIDTH;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave SEND only when the final word goes without a reload.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (p_load) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_xfer && w_cnt_zero && !p_load) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shift register and word counter: capture on an accepted load, advance
    // on a non-final transfer, otherwise hold (backpressure and idle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load_acc) begin
            r_shift <= w_padded;
            r_cnt   <= C_FIRST_CNT;
        end else if (w_xfer && !w_cnt_zero) begin
            r_shift <= w_shifted;
            r_cnt   <= r_cnt - C_CNT_ONE;
        end
    end

endmodule : p_out_serializer

`default_nettype wire

// File: tb/tb_p_out_serializer.sv
// ============================================================================
//  Module      : tb_p_out_serializer
//  Description : Self-checking bench for p_out_serializer. Two instances share
//                all inputs: one LSW-first, one MSW-first. Directed scenarios
//                plus a randomized run against a queue-based word model.
//  Options     : P_OUT_SERIALIZER_SIGN_EXT_EN selects sign-filled padding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_p_out_serializer;

    logic        clk;
    logic        rst;
    logic [47:0] p_in;
    logic        p_load;
    logic        dout_ready;

    logic        a_lr, a_valid, a_last, a_busy;
    logic [17:0] a_dout;
    logic        b_lr, b_valid, b_last, b_busy;
    logic [17:0] b_dout;

    int n_cmp;
    int n_err;

    p_out_serializer #(.P_WIDTH(48), .W_WIDTH(18), .MSW_FIRST(0)) u_dut_lsw (
        .clk        (clk),
        .rst        (rst),
        .p_in       (p_in),
        .p_load     (p_load),
        .load_ready (a_lr),
        .dout       (a_dout),
        .dout_valid (a_valid),
        .dout_ready (dout_ready),
        .dout_last  (a_last),
        .busy       (a_busy)
    );

    p_out_serializer #(.P_WIDTH(48), .W_WIDTH(18), .MSW_FIRST(1)) u_dut_msw (
        .clk        (clk),
        .rst        (rst),
        .p_in       (p_in),
        .p_load     (p_load),
        .load_ready (b_lr),
        .dout       (b_dout),
        .dout_valid (b_valid),
        .dout_ready (dout_ready),
        .dout_last  (b_last),
        .busy       (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: word idx (in stream order) of a 48-bit result split into
    // three 18-bit words after widening to 54 bits.
    function automatic logic [17:0] exp_word(input logic [47:0] v, input int idx, input bit msw);
        logic [53:0] ext;
        int          pos;
`ifdef P_OUT_SERIALIZER_SIGN_EXT_EN
        ext = {{6{v[47]}}, v};
`else
        ext = {6'b0, v};
`endif
        pos = msw ? (2 - idx) : idx;
        return ext[pos*18 +: 18];
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; p_load = 1'b0; dout_ready = 1'b0; p_in = '0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_last !== 1'b0 || b_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b/%b want 0/0", a_last, b_last); end
        n_cmp++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b/%b want 0/0", a_busy, b_busy); end
        n_cmp++; if (a_dout !== 18'h0 || b_dout !== 18'h0) begin n_err++; $display("FAIL reset_dout: got %h/%h want 0/0", a_dout, b_dout); end
        rst = 1'b0;
        cyc();
        n_cmp++; if (a_lr !== 1'b1 || b_lr !== 1'b1) begin n_err++; $display("FAIL reset_load_ready: got %b/%b want 1/1", a_lr, b_lr); end
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b/%b want 0/0", a_valid, b_valid); end
    endtask

    task automatic test_single();
        logic [17:0] ea[3];
        logic [17:0] eb[3];
        ea[0] = 18'h00001; ea[1] = 18'h00001; ea[2] = 18'h00000;
        eb[0] = 18'h00000; eb[1] = 18'h00001; eb[2] = 18'h00001;
        p_in = 48'h0000_0004_0001; p_load = 1'b1; dout_ready = 1'b1;
        cyc();
        p_load = 1'b0; p_in = 48'hABCD_EF01_2345;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (a_valid !== 1'b1 || b_valid !== 1'b1) begin n_err++; $display("FAIL single_valid w%0d: got %b/%b want 1/1", i, a_valid, b_valid); end
            n_cmp++; if (a_dout !== ea[i]) begin n_err++; $display("FAIL single_lsw w%0d: got %h want %h", i, a_dout, ea[i]); end
            n_cmp++; if (b_dout !== eb[i]) begin n_err++; $display("FAIL single_msw w%0d: got %h want %h", i, b_dout, eb[i]); end
            n_cmp++; if (a_last !== (i == 2) || b_last !== (i == 2)) begin n_err++; $display("FAIL single_last w%0d: got %b/%b want %b", i, a_last, b_last, (i == 2)); end
            cyc();
        end
        n_cmp++; if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_valid !== 1'b0 || a_last !== 1'b0) begin
            n_err++; $display("FAIL single_end: busy %b/%b valid %b last %b want all 0", a_busy, b_busy, a_valid, a_last); end
    endtask

    task automatic test_padding();
        logic [17:0] ea[3];
        logic [17:0] eb[3];
        logic [17:0] top;
`ifdef P_OUT_SERIALIZER_SIGN_EXT_EN
        top = 18'h3FFFF;
`else
        top = 18'h00FFF;
`endif
        ea[0] = 18'h3FFFF; ea[1] = 18'h3FFFF; ea[2] = top;
        eb[0] = top;       eb[1] = 18'h3FFFF; eb[2] = 18'h3FFFF;
        p_in = 48'hFFFF_FFFF_FFFF; p_load = 1'b1; dout_ready = 1'b1;
        cyc();
        p_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (a_dout !== ea[i] || a_valid !== 1'b1) begin n_err++; $display("FAIL pad_lsw w%0d: got %h v%b want %h v1", i, a_dout, a_valid, ea[i]); end
            n_cmp++; if (b_dout !== eb[i] || b_valid !== 1'b1) begin n_err++; $display("FAIL pad_msw w%0d: got %h v%b want %h v1", i, b_dout, b_valid, eb[i]); end
            cyc();
        end
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL pad_end_valid: got %b want 0", a_valid); end
    endtask

    task automatic test_backpressure();
        logic [47:0] v;
        int          xfers;
        v = 48'h1234_5678_9ABC; xfers = 0;
        p_in = v; p_load = 1'b1; dout_ready = 1'b1;
        cyc();
        p_load = 1'b0;
        n_cmp++; if (a_dout !== exp_word(v, 0, 0)) begin n_err++; $display("FAIL bp_w0: got %h want %h", a_dout, exp_word(v, 0, 0)); end
        xfers++;
        cyc();
        dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_cmp++; if (a_valid !== 1'b1 || a_dout !== exp_word(v, 1, 0) || a_last !== 1'b0) begin
                n_err++; $display("FAIL bp_hold c%0d: got %h v%b l%b want %h v1 l0", k, a_dout, a_valid, a_last, exp_word(v, 1, 0)); end
            n_cmp++; if (b_dout !== exp_word(v, 1, 1)) begin n_err++; $display("FAIL bp_hold_msw c%0d: got %h want %h", k, b_dout, exp_word(v, 1, 1)); end
            n_cmp++; if (a_lr !== 1'b0) begin n_err++; $display("FAIL bp_load_ready c%0d: got %b want 0", k, a_lr); end
        end
        dout_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            n_cmp++; if (a_valid !== 1'b1 || a_dout !== exp_word(v, i, 0)) begin n_err++; $display("FAIL bp_w%0d: got %h v%b want %h v1", i, a_dout, a_valid, exp_word(v, i, 0)); end
            if (a_valid === 1'b1) xfers++;
            cyc();
        end
        n_cmp++; if (xfers !== 3 || a_valid !== 1'b0) begin n_err++; $display("FAIL bp_count: got %0d xfers valid %b want 3 valid 0", xfers, a_valid); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] va, vb;
        va = 48'h1; vb = 48'h2;
        p_in = va; p_load = 1'b1; dout_ready = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (a_dout !== exp_word(va, i, 0) || b_dout !== exp_word(va, i, 1)) begin
                n_err++; $display("FAIL b2b_a w%0d: got %h/%h want %h/%h", i, a_dout, b_dout, exp_word(va, i, 0), exp_word(va, i, 1)); end
            p_load = 1'b1;
            p_in   = (i < 2) ? 48'hDEAD_BEEF_0000 : vb;
            #1;
            n_cmp++; if (a_lr !== (i == 2) || b_lr !== (i == 2)) begin n_err++; $display("FAIL b2b_load_ready w%0d: got %b/%b want %b", i, a_lr, b_lr, (i == 2)); end
            cyc();
        end
        p_load = 1'b0; p_in = 48'hDEAD_BEEF_0000;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (a_valid !== 1'b1 || a_dout !== exp_word(vb, i, 0) || b_dout !== exp_word(vb, i, 1)) begin
                n_err++; $display("FAIL b2b_b w%0d: got %h/%h v%b want %h/%h v1", i, a_dout, b_dout, a_valid, exp_word(vb, i, 0), exp_word(vb, i, 1)); end
            cyc();
        end
        n_cmp++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_err++; $display("FAIL b2b_end: busy %b/%b want 0/0", a_busy, b_busy); end
    endtask

    task automatic test_async_reset();
        logic [47:0] v;
        v = 48'h0000_0004_0001;
        p_in = 48'h3333_2222_1111; p_load = 1'b1; dout_ready = 1'b1;
        cyc();
        p_load = 1'b0;
        cyc();
        n_cmp++; if (a_dout !== exp_word(48'h3333_2222_1111, 1, 0)) begin n_err++; $display("FAIL arst_pre_w1: got %h want %h", a_dout, exp_word(48'h3333_2222_1111, 1, 0)); end
        dout_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_last !== 1'b0 || b_valid !== 1'b0) begin
            n_err++; $display("FAIL arst_immediate: valid %b busy %b last %b bvalid %b want 0", a_valid, a_busy, a_last, b_valid); end
        n_cmp++; if (a_dout !== 18'h0 || b_dout !== 18'h0) begin n_err++; $display("FAIL arst_dout: got %h/%h want 0/0", a_dout, b_dout); end
        p_load = 1'b1; p_in = 48'h7777_7777_7777;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; p_load = 1'b0;
        #1;
        n_cmp++; if (a_lr !== 1'b1 || a_valid !== 1'b0) begin n_err++; $display("FAIL arst_release: load_ready %b valid %b want 1 0", a_lr, a_valid); end
        @(negedge clk);
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL arst_residual: valid %b/%b want 0/0", a_valid, b_valid); end
        p_in = v; p_load = 1'b1; dout_ready = 1'b1;
        cyc();
        p_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (a_valid !== 1'b1 || a_dout !== exp_word(v, i, 0) || b_dout !== exp_word(v, i, 1)) begin
                n_err++; $display("FAIL arst_restream w%0d: got %h/%h v%b want %h/%h v1", i, a_dout, b_dout, a_valid, exp_word(v, i, 0), exp_word(v, i, 1)); end
            cyc();
        end
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL arst_end: valid %b want 0", a_valid); end
    endtask

    // Random traffic: every accepted result queues its words; each transfer
    // pops one. dout must always show the queue head.
    task automatic test_random();
        logic [17:0] qa[$];
        logic [17:0] qb[$];
        logic [47:0] v;
        logic        rdy, ld, exp_lr;
        for (int c = 0; c < 600; c++) begin
            n_cmp++; if (a_valid !== (qa.size() != 0) || b_valid !== (qb.size() != 0) || a_busy !== (qa.size() != 0)) begin
                n_err++; $display("FAIL rnd_valid c%0d: got %b/%b busy %b want %b", c, a_valid, b_valid, a_busy, (qa.size() != 0)); end
            if (qa.size() != 0) begin
                n_cmp++; if (a_dout !== qa[0] || b_dout !== qb[0]) begin
                    n_err++; $display("FAIL rnd_dout c%0d: got %h/%h want %h/%h", c, a_dout, b_dout, qa[0], qb[0]); end
                n_cmp++; if (a_last !== (qa.size() == 1) || b_last !== (qb.size() == 1)) begin
                    n_err++; $display("FAIL rnd_last c%0d: got %b/%b want %b", c, a_last, b_last, (qa.size() == 1)); end
            end
            if (c >= 590) begin
                rdy = 1'b1; ld = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 9) < 7);
                ld  = ($urandom_range(0, 9) < 4);
            end
            case ($urandom_range(0, 7))
                0:       v = 48'hFFFF_FFFF_FFFF;
                1:       v = 48'h0;
                2:       v = 48'h8000_0000_0000;
                default: v = {16'($urandom), $urandom};
            endcase
            dout_ready = rdy; p_load = ld; p_in = v;
            #1;
            exp_lr = (qa.size() == 0) || (qa.size() == 1 && rdy);
            n_cmp++; if (a_lr !== exp_lr || b_lr !== exp_lr) begin n_err++; $display("FAIL rnd_load_ready c%0d: got %b/%b want %b", c, a_lr, b_lr, exp_lr); end
            if (qa.size() != 0 && rdy) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (ld && exp_lr) begin
                for (int i = 0; i < 3; i++) begin
                    qa.push_back(exp_word(v, i, 0));
                    qb.push_back(exp_word(v, i, 1));
                end
            end
            cyc();
        end
        p_load = 1'b0;
        n_cmp++; if (a_valid !== 1'b0 || qa.size() != 0) begin n_err++; $display("FAIL rnd_drain: valid %b queued %0d want 0 0", a_valid, qa.size()); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; p_load = 1'b0; dout_ready = 1'b0; p_in = '0;
        test_reset();
        test_single();
        test_padding();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_p_out_serializer

`default_nettype wire
